// File: rtl/id_issue_fifo.sv
// Decode-to-issue FIFO carrying an opaque decoded payload and a control-flow flag.
// It also owns runtime-monitor lane allocation, binding a one-hot lane to each entry at enqueue.
module id_issue_fifo #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 64,
  parameter int NUM_LANES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_ctrl_flow_i,
  input  logic                       in_monitor_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_ctrl_flow_o,
  output logic [NUM_LANES-1:0]       out_lane_o,
  output logic                       out_valid_o,
  input  logic                       out_ack_i,
  input  logic [NUM_LANES-1:0]       lane_release_i,
  output logic [NUM_LANES-1:0]       lanes_busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Handshake: an entry moves on a cycle where valid and ready are both high.
  // in_ready_o depends on in_valid_i and out_ack_i, so a full FIFO accepts on the cycle its head is taken.

  logic [DATA_W-1:0]    data_q [DEPTH];
  logic                 ctrl_q [DEPTH];
  logic [NUM_LANES-1:0] lane_q [DEPTH];

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_LANES-1:0] busy_q, busy_d;

  logic                 empty;
  logic                 deq;
  logic                 enq;
  logic                 alloc_found;
  logic [NUM_LANES-1:0] alloc_lane;
  logic [NUM_LANES-1:0] new_lane;
  logic [NUM_LANES-1:0] flush_free;

  assign empty      = (count_q == '0);
  assign deq        = out_ack_i && !empty;
  assign in_ready_o = !flush_i && in_valid_i && ((count_q < CNT_W'(DEPTH)) || deq);
  assign enq        = in_ready_o;

  // Lowest free lane; allocation sees busy_q only, so same-cycle releases are not reused.
  always_comb begin
    alloc_lane  = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!alloc_found && !busy_q[i]) begin
        alloc_lane[i] = 1'b1;
        alloc_found   = 1'b1;
      end
    end
  end

  assign new_lane = (enq && in_monitor_i) ? alloc_lane : '0;

  // Lanes held by entries dropped by a flush; an acked head counts as issued and keeps its lane.
  always_comb begin
    flush_free = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && !((k == 0) && deq)) begin
        flush_free = flush_free | lane_q[rd_ptr_q + PTR_W'(k)];
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q & ~lane_release_i;
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (flush_i) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
      busy_d   = busy_d & ~flush_free;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, deq};
    end
    busy_d = busy_d | new_lane;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Payload storage needs no reset: the head outputs are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_q[wr_ptr_q] <= in_data_i;
      ctrl_q[wr_ptr_q] <= in_ctrl_flow_i;
      lane_q[wr_ptr_q] <= new_lane;
    end
  end

  always_comb begin
    out_valid_o     = !empty;
    out_data_o      = '0;
    out_ctrl_flow_o = 1'b0;
    out_lane_o      = '0;
    if (!empty) begin
      out_data_o      = data_q[rd_ptr_q];
      out_ctrl_flow_o = ctrl_q[rd_ptr_q];
      out_lane_o      = lane_q[rd_ptr_q];
    end
  end

  assign lanes_busy_o = busy_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_id_issue_fifo.sv
// Bench for id_issue_fifo: directed vector table, hand sequences for flush/reset, and random traffic
// checked against a queue-based reference model.
module tb_id_issue_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int NL    = 4;

  logic          clk;
  logic          rst_n;
  logic          fl, cf_in, mon_in, v_in, ack_in;
  logic [DW-1:0] d_in;
  logic [NL-1:0] rel_in;
  logic          in_ready, out_valid, out_cf;
  logic [DW-1:0] out_data;
  logic [NL-1:0] out_lane, busy;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  id_issue_fifo #(.DEPTH(DEPTH), .DATA_W(DW), .NUM_LANES(NL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl),
    .in_data_i(d_in), .in_ctrl_flow_i(cf_in), .in_monitor_i(mon_in), .in_valid_i(v_in),
    .in_ready_o(in_ready),
    .out_data_o(out_data), .out_ctrl_flow_o(out_cf), .out_lane_o(out_lane), .out_valid_o(out_valid),
    .out_ack_i(ack_in), .lane_release_i(rel_in), .lanes_busy_o(busy), .count_o(count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of entries plus a lane-busy bitmap
  typedef struct {
    logic [DW-1:0] d;
    logic          cf;
    logic [NL-1:0] lane;
  } ent_t;
  ent_t          mq[$];
  logic [NL-1:0] mbusy;

  function automatic logic [NL-1:0] first_free(input logic [NL-1:0] b);
    for (int i = 0; i < NL; i++) if (!b[i]) return NL'(1) << i;
    return '0;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver: apply inputs, let comb logic settle, compare against the model
  task automatic present(input logic f, input logic [DW-1:0] d, input logic c, input logic m,
                         input logic v, input logic a, input logic [NL-1:0] r);
    logic e_deq;
    fl = f; d_in = d; cf_in = c; mon_in = m; v_in = v; ack_in = a; rel_in = r;
    #1;
    e_deq = a && (mq.size() > 0);
    chk("m_ready", DW'(in_ready), DW'(!f && v && (mq.size() < DEPTH || e_deq)));
    chk("m_valid", DW'(out_valid), DW'(mq.size() > 0));
    chk("m_data",  out_data, (mq.size() > 0) ? mq[0].d : '0);
    chk("m_cf",    DW'(out_cf), DW'((mq.size() > 0) ? mq[0].cf : 1'b0));
    chk("m_lane",  DW'(out_lane), DW'((mq.size() > 0) ? mq[0].lane : '0));
    chk("m_count", DW'(count), DW'(mq.size()));
    chk("m_busy",  DW'(busy), DW'(mbusy));
  endtask

  task automatic tick();
    logic          e_deq, e_rdy;
    logic [NL-1:0] lane, free;
    ent_t          e;
    @(posedge clk);
    e_deq = ack_in && (mq.size() > 0);
    e_rdy = !fl && v_in && (mq.size() < DEPTH || e_deq);
    lane  = (e_rdy && mon_in) ? first_free(mbusy) : '0;
    if (e_deq) e = mq.pop_front();
    free = '0;
    if (fl) begin
      foreach (mq[i]) free |= mq[i].lane;
      mq.delete();
    end
    if (e_rdy) begin
      e.d = d_in; e.cf = cf_in; e.lane = lane;
      mq.push_back(e);
    end
    mbusy = (mbusy & ~rel_in & ~free) | lane;
    #1;
  endtask

  typedef struct {
    logic          f, c, m, v, a;
    logic [DW-1:0] d;
    logic [NL-1:0] r;
    logic          e_ready, e_valid;
    logic [DW-1:0] e_data;
    logic [NL-1:0] e_lane, e_busy;
    logic [2:0]    e_count;
  } vec_t;
  vec_t vt[16];

  localparam logic [DW-1:0] A = 64'hA, B = 64'hB, C = 64'hC, D = 64'hD, E = 64'hE;
  localparam logic [DW-1:0] F = 64'hF, G = 64'h10, H = 64'h11, I = 64'h12, J = 64'h13;

  initial begin
    //        f  c  m  v  a  data r        rdy vld data  lane     busy     cnt
    vt[0]  = '{0, 0, 1, 1, 0, A, 4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 3'd0};
    vt[1]  = '{0, 1, 0, 1, 0, B, 4'b0000, 1, 1, A,     4'b0001, 4'b0001, 3'd1};
    vt[2]  = '{0, 0, 1, 1, 0, C, 4'b0000, 1, 1, A,     4'b0001, 4'b0001, 3'd2};
    vt[3]  = '{0, 0, 1, 1, 0, D, 4'b0000, 1, 1, A,     4'b0001, 4'b0011, 3'd3};
    vt[4]  = '{0, 0, 1, 1, 0, E, 4'b0000, 0, 1, A,     4'b0001, 4'b0111, 3'd4};
    vt[5]  = '{0, 0, 1, 1, 1, E, 4'b0000, 1, 1, A,     4'b0001, 4'b0111, 3'd4};
    vt[6]  = '{0, 0, 0, 0, 1, 0, 4'b0000, 0, 1, B,     4'b0000, 4'b1111, 3'd4};
    vt[7]  = '{0, 0, 1, 1, 0, F, 4'b0100, 1, 1, C,     4'b0010, 4'b1111, 3'd3};
    vt[8]  = '{0, 0, 1, 1, 1, G, 4'b0000, 1, 1, C,     4'b0010, 4'b1011, 3'd4};
    vt[9]  = '{1, 0, 1, 1, 1, J, 4'b0000, 0, 1, D,     4'b0100, 4'b1111, 3'd4};
    vt[10] = '{0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 64'h0, 4'b0000, 4'b0011, 3'd0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 64'h0, 4'b0000, 4'b0011, 3'd0};
    vt[12] = '{0, 0, 1, 1, 0, H, 4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 3'd0};
    vt[13] = '{0, 0, 1, 1, 0, I, 4'b0000, 1, 1, H,     4'b0001, 4'b0001, 3'd1};
    vt[14] = '{1, 0, 1, 1, 1, J, 4'b0000, 0, 1, H,     4'b0001, 4'b0011, 3'd2};
    vt[15] = '{0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 64'h0, 4'b0000, 4'b0001, 3'd0};

    rst_n = 1'b0;
    fl = 0; d_in = '0; cf_in = 0; mon_in = 0; v_in = 0; ack_in = 0; rel_in = '0;
    mbusy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_count", DW'(count), '0);
    chk("rst_busy",  DW'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 16; n++) begin
      present(vt[n].f, vt[n].d, vt[n].c, vt[n].m, vt[n].v, vt[n].a, vt[n].r);
      chk($sformatf("v%0d_ready", n), DW'(in_ready),  DW'(vt[n].e_ready));
      chk($sformatf("v%0d_valid", n), DW'(out_valid), DW'(vt[n].e_valid));
      chk($sformatf("v%0d_data", n),  out_data,       vt[n].e_data);
      chk($sformatf("v%0d_lane", n),  DW'(out_lane),  DW'(vt[n].e_lane));
      chk($sformatf("v%0d_busy", n),  DW'(busy),      DW'(vt[n].e_busy));
      chk($sformatf("v%0d_count", n), DW'(count),     DW'(vt[n].e_count));
      tick();
    end

    // Async reset mid-stream with count=3, busy=0111
    for (int n = 0; n < 3; n++) begin
      present(0, DW'(100 + n), 0, 1, 1, 0, '0);
      tick();
    end
    present(0, '0, 0, 0, 0, 0, '0);
    chk("pre_rst_count", DW'(count), DW'(3));
    chk("pre_rst_busy",  DW'(busy), DW'(4'b0111));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(out_valid), '0);
    chk("arst_data",  out_data, '0);
    chk("arst_lane",  DW'(out_lane), '0);
    chk("arst_cf",    DW'(out_cf), '0);
    chk("arst_busy",  DW'(busy), '0);
    chk("arst_count", DW'(count), '0);
    mq.delete();
    mbusy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    present(0, 64'h55, 0, 1, 1, 0, '0);
    tick();
    present(0, '0, 0, 0, 0, 0, '0);
    chk("post_rst_lane", DW'(out_lane), DW'(4'b0001));
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      present(($urandom_range(0, 19) == 0),
              {$urandom, $urandom},
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 5),
              ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, 15)) : '0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_fifo.md
Name: id_issue_fifo

Overview:
Parametrised successor to the single-register ID/issue pipeline stage. It buffers up to DEPTH decoded instructions between decode and issue, carrying each entry's control-flow flag. It owns runtime-monitor lane allocation: a one-hot lane is assigned at enqueue time and freed on commit release or on flush. It sits between the decoder and the issue stage, and the whole decoded entry is treated as an opaque DATA_W payload.

Parameters:
DEPTH, 4, number of buffered entries; power of two, >= 2
DATA_W, 64, width of the decoded-entry payload
NUM_LANES, 4, number of runtime-monitor lanes; >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all queued entries
in_data_i  in  DATA_W  decoded instruction payload
in_ctrl_flow_i  in  1  entry is a control-flow instruction
in_monitor_i  in  1  entry requests a monitor lane
in_valid_i  in  1  decoder offers an entry
in_ready_o  out  1  entry accepted this cycle
out_data_o  out  DATA_W  head payload
out_ctrl_flow_o  out  1  head control-flow flag
out_lane_o  out  NUM_LANES  head lane, one-hot; all-zero means no lane
out_valid_o  out  1  head valid
out_ack_i  in  1  issue stage takes the head
lane_release_i  in  NUM_LANES  commit frees these lanes
lanes_busy_o  out  NUM_LANES  lane busy bitmap (registered)
count_o  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async, rst_ni=0):
  - read/write pointers, count and busy bitmap cleared.
  - out_valid_o=0, out_data_o=0, out_ctrl_flow_o=0, out_lane_o=0, lanes_busy_o=0, count_o=0.
  - Reset mid-operation discards all entries and lanes immediately.
- Storage: circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.
- Dequeue:
  - deq = out_ack_i && out_valid_o.
  - out_ack_i while empty is ignored.
- Enqueue and ready:
  - in_ready_o = !flush_i && in_valid_i && (count<DEPTH || deq). This is combinational, so a full FIFO accepts on the same cycle it is acked.
  - enq = in_ready_o.
- Latency:
  - An enqueued entry is visible at the head no earlier than the next cycle; there is no same-cycle bypass.
  - out_* are driven from the head slot. out_data_o, out_ctrl_flow_o and out_lane_o are 0 when empty.
- Count update: count_n = count + enq - deq. Simultaneous enq and deq at count=DEPTH leaves count=DEPTH.
- Lane allocation (on enq with in_monitor_i=1):
  - the lane chosen is the lowest index i with busy_q[i]=0; the one-hot bit is stored with the entry.
  - If all lanes are busy, the entry is stored with lane=0 and is still accepted (no stall).
  - in_monitor_i=0 stores lane=0.
  - Allocation considers busy_q only. A lane released this cycle is not reusable until the next cycle.
- Busy bitmap update:
  - busy_n = (busy_q & ~lane_release_i & ~flush_free) | alloc.
  - Releasing a non-busy lane is ignored.
  - Dequeue does not free a lane; the lane stays busy until lane_release_i.
- Flush (flush_i=1):
  - next cycle count=0, pointers equal and out_valid_o=0.
  - flush_free = OR of the lanes of all entries still queued, excluding the head if deq is asserted the same cycle; that head counts as issued and its lane stays busy.
  - No enqueue occurs during flush.
  - lane_release_i in the flush cycle is still applied.
- lanes_busy_o = busy_q.

Test Plan:
- Reset, then push A,B,C with in_monitor_i=1,0,1 and NUM_LANES=4 -> lanes 0001, 0000, 0010; count_o=3; lanes_busy_o=0011; A appears 1 cycle after its enqueue.
- Fill to DEPTH=4 with no ack, then in_valid_i=1 -> in_ready_o=0. Assert out_ack_i and in_valid_i together -> in_ready_o=1, count_o stays 4, FIFO order preserved across pointer wrap.
- Busy=1111 and a monitored enqueue -> entry stored with lane 0000. Same cycle lane_release_i=0100 -> busy=1011 next cycle, and the following monitored enqueue gets 0100.
- Queue holds entries with lanes 0001 (head) and 0010; flush_i with out_ack_i -> next cycle count_o=0, out_valid_o=0, lanes_busy_o=0001.
- Flush with in_valid_i=1 -> in_ready_o=0; nothing enqueued, count_o=0 next cycle.
- rst_ni low mid-stream with count=3, busy=0111 -> all outputs 0 asynchronously; after release, the first monitored enqueue gets lane 0001.
